pc_exc_unit: RTL

Parametrised program-counter and exception/interrupt sequencer for the single-cycle MIPS core. It replaces the fixed single-IRQ PC logic with:
- N interrupt channels, each with a pending latch and a mask bit;
- fixed priority, optionally vectored entry;
- EPC/cause capture and `eret` return;
- a stall input.

It sits between the decoder (which supplies `pc_src`, `undef` and `eret`) and instruction ROM addressing. Kernel mode is `pc[31]`.

---
 rtl/pc_exc_pkg.sv | 31 +++
 rtl/pc_exc_unit_irq_arbiter.sv | 63 ++++++
 rtl/pc_exc_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_exc_pkg.sv
// pc_exc_pkg
// Shared definitions for the program-counter / exception sequencer:
//   - pc_src_e     : next-PC source selected by the decoder
//   - DEF_*        : default reset, interrupt, undefined-instruction and
//                    vector-table addresses
//   - cause_width  : width of the cause register for a given channel count
//   - cause_undef  : cause code reported for an undefined instruction
package pc_exc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP    = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR     = 32'h8000_0008;
    localparam logic [31:0] DEF_VEC_BASE = 32'h8000_0040;

    // Codes 0..nirq-1 name an interrupt channel, nirq names undef.
    function automatic int cause_width(input int nirq);
        return $clog2(nirq + 1);
    endfunction

    function automatic int cause_undef(input int nirq);
        return nirq;
    endfunction

endpackage

// File: rtl/pc_exc_unit_irq_arbiter.sv
// irq_arbiter
// Interrupt front end: per-channel edge/level capture into a pending latch,
// a mask register, and a fixed-priority encoder (lowest index wins).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   irq[NIRQ]           : raw interrupt lines
//   mask_we, mask_wdata : mask register write (visible the following cycle)
//   ack[NIRQ]           : one-hot clear of the channel being taken this cycle
//   valid               : at least one pending and unmasked channel
//   idx[CW]             : index of the winning channel
//   pending[NIRQ]       : pending latch contents
module irq_arbiter
    import pc_exc_pkg::*;
#(
    parameter int              NIRQ       = 4,
    parameter logic [NIRQ-1:0] LEVEL_MASK = '1,
    parameter int              CW         = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    input  logic [NIRQ-1:0] ack,
    output logic            valid,
    output logic [CW-1:0]   idx,
    output logic [NIRQ-1:0] pending
);

    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] set;
    logic [NIRQ-1:0] eligible;

    // Level channels request while high; edge channels only on a 0->1 step.
    assign set      = (irq & LEVEL_MASK) | (irq & ~irq_q & ~LEVEL_MASK);
    assign eligible = pending & mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '1;
        end else begin
            irq_q   <= irq;
            // A new request in the same cycle as its ack keeps the bit set.
            pending <= (pending & ~ack) | set;
            if (mask_we)
                mask <= mask_wdata;
        end
    end

    // Scan downwards so the lowest eligible index is the last to assign.
    always_comb begin
        valid = |eligible;
        idx   = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i])
                idx = CW'(i);
        end
    end

endmodule

// File: rtl/pc_exc_unit.sv
// pc_exc_unit
// Program counter and exception/interrupt sequencer for the single-cycle
// MIPS core. Kernel mode is pc[31]; interrupts and undefined-instruction
// traps are only taken from user mode and never nest.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   stall             : hold pc/epc/cause, suppress traps
//   pc_src, branch    : next-PC select and branch condition
//   conba, jt, data_a0: branch target, jump field, register jump target
//   undef, eret       : decoder flags for illegal instruction / return
//   irq               : raw interrupt lines
//   mask_we/mask_wdata: interrupt mask write
//   pc, epc, cause    : architectural registers
//   trap              : current instruction squashed, exception taken now
//   irq_ack           : registered one-hot pulse of the channel taken
//   pending           : pending latch contents
module pc_exc_unit
    import pc_exc_pkg::*;
#(
    parameter int              NIRQ       = 4,
    parameter logic [NIRQ-1:0] LEVEL_MASK = '1,
    parameter bit              VECTORED   = 1'b0,
    parameter logic [31:0]     RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0]     ILLOP      = DEF_ILLOP,
    parameter logic [31:0]     XADR       = DEF_XADR,
    parameter logic [31:0]     VEC_BASE   = DEF_VEC_BASE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [1:0]                   pc_src,
    input  logic                         branch,
    input  logic [31:0]                  conba,
    input  logic [25:0]                  jt,
    input  logic [31:0]                  data_a0,
    input  logic                         undef,
    input  logic                         eret,
    input  logic [NIRQ-1:0]              irq,
    input  logic                         mask_we,
    input  logic [NIRQ-1:0]              mask_wdata,
    output logic [31:0]                  pc,
    output logic [31:0]                  epc,
    output logic [cause_width(NIRQ)-1:0] cause,
    output logic                         trap,
    output logic [NIRQ-1:0]              irq_ack,
    output logic [NIRQ-1:0]              pending
);

    localparam int            CW         = cause_width(NIRQ);
    localparam logic [CW-1:0] UNDEF_CODE = CW'(cause_undef(NIRQ));

    logic            kernel;
    logic            arb_valid;
    logic [CW-1:0]   arb_idx;
    logic            irq_take;
    logic            undef_take;
    logic [NIRQ-1:0] ack_now;
    logic [31:0]     pc_plus4;
    logic [31:0]     irq_entry;
    logic [31:0]     flow_next;
    logic [31:0]     pc_next;

    irq_arbiter #(
        .NIRQ       (NIRQ),
        .LEVEL_MASK (LEVEL_MASK),
        .CW         (CW)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack_now),
        .valid      (arb_valid),
        .idx        (arb_idx),
        .pending    (pending)
    );

    assign kernel   = pc[31];
    assign pc_plus4 = pc + 32'd4;

    // An interrupt beats a simultaneous undef; the undef instruction is
    // simply re-fetched after eret and traps then.
    assign irq_take   = arb_valid & ~kernel & ~stall & ~reset;
    assign undef_take = undef & ~arb_valid & ~kernel & ~stall & ~reset;
    assign trap       = irq_take | undef_take;
    assign ack_now    = irq_take ? (NIRQ'(1) << arb_idx) : '0;
    assign irq_entry  = VECTORED ? (VEC_BASE + (32'(arb_idx) << 3)) : ILLOP;

    always_comb begin
        flow_next = pc_plus4;
        case (pc_src_e'(pc_src))
            PC_SEQ:    flow_next = pc_plus4;
            PC_BRANCH: flow_next = branch ? conba : pc_plus4;
            PC_JUMP:   flow_next = {pc[31:28], jt, 2'b00};
            PC_REG:    flow_next = data_a0;
            default:   flow_next = pc_plus4;
        endcase
    end

    // Ignored eret (user mode) and ignored undef (kernel mode) both fall
    // through to plain sequential execution.
    always_comb begin
        pc_next = flow_next;
        if (irq_take)
            pc_next = irq_entry;
        else if (undef_take)
            pc_next = XADR;
        else if (eret && kernel)
            pc_next = epc;
        else if (eret || undef)
            pc_next = pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            epc     <= '0;
            cause   <= '0;
            irq_ack <= '0;
        end else begin
            irq_ack <= ack_now;
            if (!stall) begin
                pc <= pc_next;
                if (trap) begin
                    epc   <= pc;
                    cause <= irq_take ? arb_idx : UNDEF_CODE;
                end
            end
        end
    end

endmodule
